switch_mcu_alu_seq: RTL and testbench
=====================================

SWITCH_MCU_ALU_SEQ -- requirements
Module: switch_mcu_alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 32, 64).
REQ-002 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter SHIFT_SERIAL, default 0; 0 = single-cycle barrel shift, 1 = one-bit-per-cycle serial shift.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: in_clk input 1 (rising edge), then in_rst input 1 (asynchronous, active-high).
REQ-005 SHALL have in_start, input, 1 bit: request to execute one operation.
REQ-006 SHALL have in_op, input, 5 bits: operation code, 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI, 11 AUIPC, 12 JAL, 13 JALR, 14 BEQ, 15 BNE, 16 BLT, 17 BGE, 18 BLTU, 19 BGEU.
REQ-007 SHALL have in_rs1_data and in_rs2_data, inputs, XLEN bits each: source operands.
REQ-008 SHALL have in_imm, input, XLEN bits: sign-extended immediate; for LUI/AUIPC it is already shifted left by 12.
REQ-009 SHALL have in_use_imm, input, 1 bit: operand B = in_imm instead of in_rs2_data for ops 0-9.
REQ-010 SHALL have in_pc, input, XLEN bits: PC of the instruction.
REQ-011 SHALL have in_rd, input, RADDR_W bits: destination register.
REQ-012 SHALL have out_busy, output, 1 bit: an operation is in flight.
REQ-013 SHALL have out_done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have out_illegal, output, 1 bit: one-cycle pulse, asserted with out_done for in_op > 19.
REQ-015 SHALL have register-write outputs: out_wen (1 bit), out_waddr (RADDR_W bits), out_wdata (XLEN bits).
REQ-016 SHALL have PC-redirect outputs: out_pc_override (1 bit) and out_pc_write (XLEN bits).

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, SHIFT and DONE.
REQ-018 SHALL accept a request only when in_start=1 in IDLE; it SHALL then latch all inputs and move to EXEC.
REQ-019 SHALL ignore in_start while not in IDLE: no queuing, no effect on the latched operands.
REQ-020 SHALL assert out_busy = (state != IDLE).
REQ-021 SHALL compute non-shift ops in EXEC and go to DONE; out_done SHALL pulse exactly 2 cycles after the accept edge.
REQ-022 SHALL compute shift ops in EXEC when SHIFT_SERIAL=0.
REQ-023 SHALL, when SHIFT_SERIAL=1, load shamt (low log2(XLEN) bits of operand B) in EXEC and go to SHIFT, shifting one bit per cycle until shamt=0.
  - latency = 2 + shamt; shamt=0 goes EXEC -> DONE directly.
REQ-024 SHALL, in DONE, drive all outputs for one cycle and return to IDLE; a new in_start in the cycle after DONE SHALL be accepted.
REQ-025 SHALL wrap ADD/SUB/AUIPC results modulo 2^XLEN.
REQ-026 SHALL compare signed for SLT/BLT/BGE and unsigned for SLTU/BLTU/BGEU; SLT/SLTU SHALL write 0 or 1.
REQ-027 SHALL sign-fill SRA from bit XLEN-1.
REQ-028 SHALL write the following values:
  - LUI writes imm.
  - AUIPC writes pc+imm.
  - JAL/JALR write pc+4.
REQ-029 SHALL set PC targets as follows:
  - JAL/taken branch: out_pc_write = pc+imm.
  - JALR: out_pc_write = (rs1+imm) with bit0 cleared.
  - out_pc_override=1 in DONE for JAL, JALR and taken branches.
REQ-030 SHALL keep out_wen=0 for branches, illegal ops and in_rd=0; out_done SHALL still pulse in these cases.
REQ-031 SHALL hold out_wen, out_pc_override, out_done and out_illegal at 0 outside DONE; out_wdata, out_waddr and out_pc_write SHALL be 0 outside DONE.

Reset
REQ-032 SHALL, while in_rst=1 (asynchronous), force state to IDLE and all outputs and internal registers to 0.
REQ-033 SHALL abandon any in-flight op on reset without a done pulse; the first accept after reset release SHALL occur no earlier than the first rising edge with in_rst=0.

Verification
REQ-034 SHALL be verified with: ADD, rs1=0xFFFFFFFF, rs2=1, rd=3 -> 2 cycles later out_done=1, out_wen=1, out_waddr=3, out_wdata=0.
REQ-035 SHALL be verified with: SHIFT_SERIAL=1, SRA, rs1=0x80000000, imm=4, use_imm=1 -> busy for 6 cycles, out_wdata=0xF8000000.
REQ-036 SHALL be verified with: BLT, rs1=-1, rs2=0, pc=0x100, imm=-8 -> out_pc_override=1, out_pc_write=0xF8, out_wen=0; BLTU with the same operands -> override=0.
REQ-037 SHALL be verified with: JALR, rs1=0x203, imm=4, pc=0x40, rd=1 -> out_pc_write=0x206, out_wdata=0x44, out_waddr=1.
REQ-038 SHALL be verified with: in_start held high during a serial shift, then in_rst pulsed mid-SHIFT -> no second accept while busy; after reset no out_done, all outputs 0, state IDLE.
REQ-039 SHALL be verified with: in_op=25 -> out_done=1 and out_illegal=1 together, out_wen=0, out_pc_override=0.

Source files
------------

// File: rtl/switch_mcu_alu_seq.sv
// Sequenced RV-style ALU/branch unit.
// An accepted request is latched, evaluated in EXEC, optionally shifted one
// bit per cycle in SHIFT, and presented on the outputs for a single DONE cycle.
module switch_mcu_alu_seq #(
    parameter int XLEN         = 32,
    parameter int RADDR_W      = 5,
    parameter int SHIFT_SERIAL = 0
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_start,
    input  logic [4:0]         in_op,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_use_imm,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rd,
    output logic               out_busy,
    output logic               out_done,
    output logic               out_illegal,
    output logic               out_wen,
    output logic [RADDR_W-1:0] out_waddr,
    output logic [XLEN-1:0]    out_wdata,
    output logic               out_pc_override,
    output logic [XLEN-1:0]    out_pc_write
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_LUI  = 5'd10;
    localparam logic [4:0] OP_AUIPC = 5'd11;
    localparam logic [4:0] OP_JAL  = 5'd12;
    localparam logic [4:0] OP_JALR = 5'd13;
    localparam logic [4:0] OP_BEQ  = 5'd14;
    localparam logic [4:0] OP_BNE  = 5'd15;
    localparam logic [4:0] OP_BLT  = 5'd16;
    localparam logic [4:0] OP_BGE  = 5'd17;
    localparam logic [4:0] OP_BLTU = 5'd18;
    localparam logic [4:0] OP_BGEU = 5'd19;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t state, state_next;

    logic [4:0]         op_q;
    logic [XLEN-1:0]    a_q, rs2_q, imm_q, pc_q;
    logic               use_imm_q;
    logic [RADDR_W-1:0] rd_q;

    logic [XLEN-1:0]    wdata_q, pcw_q;
    logic               wen_q, ovr_q, ill_q;
    logic [SHW-1:0]     cnt_q;

    logic [XLEN-1:0]    op_b, sum, diff, pc_plus_imm, jalr_sum, shift_step;
    logic [SHW-1:0]     shamt;
    logic               lt_s, lt_u, is_shift, serial_shift;
    logic [XLEN-1:0]    alu_wdata, alu_target;
    logic               alu_write, alu_taken, alu_illegal;

    // State register; reset abandons any operation in flight
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Request operands are captured only on an accept from IDLE
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            op_q      <= '0;
            a_q       <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            use_imm_q <= 1'b0;
            rd_q      <= '0;
        end else if (state == IDLE && in_start) begin
            op_q      <= in_op;
            a_q       <= in_rs1_data;
            rs2_q     <= in_rs2_data;
            imm_q     <= in_imm;
            pc_q      <= in_pc;
            use_imm_q <= in_use_imm;
            rd_q      <= in_rd;
        end
    end

    // Combinational evaluation of the latched operation
    always_comb begin
        op_b         = (use_imm_q && op_q <= OP_AND) ? imm_q : rs2_q;
        shamt        = op_b[SHW-1:0];
        sum          = a_q + op_b;
        diff         = a_q - op_b;
        lt_s         = $signed(a_q) < $signed(op_b);
        lt_u         = a_q < op_b;
        pc_plus_imm  = pc_q + imm_q;
        jalr_sum     = a_q + imm_q;
        is_shift     = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
        serial_shift = (SHIFT_SERIAL != 0) && is_shift;
        alu_wdata    = '0;
        alu_target   = '0;
        alu_write    = 1'b1;
        alu_taken    = 1'b0;
        alu_illegal  = 1'b0;
        case (op_q)
            OP_ADD:   alu_wdata = sum;
            OP_SUB:   alu_wdata = diff;
            OP_SLL:   alu_wdata = (SHIFT_SERIAL != 0) ? a_q : (a_q << shamt);
            OP_SLT:   alu_wdata = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU:  alu_wdata = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:   alu_wdata = a_q ^ op_b;
            OP_SRL:   alu_wdata = (SHIFT_SERIAL != 0) ? a_q : (a_q >> shamt);
            OP_SRA:   alu_wdata = (SHIFT_SERIAL != 0) ? a_q : XLEN'($signed(a_q) >>> shamt);
            OP_OR:    alu_wdata = a_q | op_b;
            OP_AND:   alu_wdata = a_q & op_b;
            OP_LUI:   alu_wdata = imm_q;
            OP_AUIPC: alu_wdata = pc_plus_imm;
            OP_JAL: begin
                alu_wdata  = pc_q + XLEN'(4);
                alu_taken  = 1'b1;
                alu_target = pc_plus_imm;
            end
            OP_JALR: begin
                alu_wdata  = pc_q + XLEN'(4);
                alu_taken  = 1'b1;
                alu_target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                alu_write = 1'b0;
                case (op_q)
                    OP_BEQ:  alu_taken = (a_q == op_b);
                    OP_BNE:  alu_taken = (a_q != op_b);
                    OP_BLT:  alu_taken = lt_s;
                    OP_BGE:  alu_taken = !lt_s;
                    OP_BLTU: alu_taken = lt_u;
                    default: alu_taken = !lt_u;
                endcase
                alu_target = alu_taken ? pc_plus_imm : '0;
            end
            default: begin
                alu_write   = 1'b0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    // One-bit step used by the serial shifter
    always_comb begin
        case (op_q)
            OP_SLL:  shift_step = {wdata_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, wdata_q[XLEN-1:1]};
            default: shift_step = {wdata_q[XLEN-1], wdata_q[XLEN-1:1]};
        endcase
    end

    // Result registers: loaded in EXEC, walked bit by bit in SHIFT
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wdata_q <= '0;
            pcw_q   <= '0;
            wen_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                EXEC: begin
                    wdata_q <= alu_wdata;
                    pcw_q   <= alu_target;
                    wen_q   <= alu_write && (rd_q != '0);
                    ovr_q   <= alu_taken;
                    ill_q   <= alu_illegal;
                    cnt_q   <= shamt;
                end
                SHIFT: begin
                    wdata_q <= shift_step;
                    cnt_q   <= cnt_q - SHW'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; a zero serial shift amount skips SHIFT entirely
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (in_start) state_next = EXEC;
            EXEC:  state_next = (serial_shift && shamt != '0) ? SHIFT : DONE;
            SHIFT: if (cnt_q == SHW'(1)) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are presented only during the DONE cycle
    always_comb begin
        out_busy        = (state != IDLE);
        out_done        = 1'b0;
        out_illegal     = 1'b0;
        out_wen         = 1'b0;
        out_waddr       = '0;
        out_wdata       = '0;
        out_pc_override = 1'b0;
        out_pc_write    = '0;
        if (state == DONE) begin
            out_done        = 1'b1;
            out_illegal     = ill_q;
            out_wen         = wen_q;
            out_waddr       = rd_q;
            out_wdata       = wdata_q;
            out_pc_override = ovr_q;
            out_pc_write    = pcw_q;
        end
    end

endmodule

// File: tb/tb_switch_mcu_alu_seq.sv
// Bench for switch_mcu_alu_seq: a barrel-shift and a serial-shift instance
// share stimulus and are compared against an arithmetic reference model.
module tb_switch_mcu_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [4:0]  op;
    logic [31:0] rs1, rs2, imm, pc;
    logic        use_imm;
    logic [4:0]  rd;

    logic        p_busy, p_done, p_ill, p_wen, p_ovr;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata, p_pcw;
    logic        s_busy, s_done, s_ill, s_wen, s_ovr;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata, s_pcw;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        busy, done, ill, wen, ovr;
        logic [4:0]  waddr;
        logic [31:0] wdata, pcw;
    } obs_t;

    typedef struct {
        logic [31:0] wdata;
        logic        wen;
        logic        ovr;
        logic [31:0] pcw;
        logic        ill;
        bit          is_shift;
        int          shamt;
    } exp_t;

    string dn[2] = '{"par", "ser"};

    always #5 clk = ~clk;

    switch_mcu_alu_seq #(.XLEN(32), .RADDR_W(5), .SHIFT_SERIAL(0)) u_par (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_op(op),
        .in_rs1_data(rs1), .in_rs2_data(rs2), .in_imm(imm), .in_use_imm(use_imm),
        .in_pc(pc), .in_rd(rd), .out_busy(p_busy), .out_done(p_done),
        .out_illegal(p_ill), .out_wen(p_wen), .out_waddr(p_waddr),
        .out_wdata(p_wdata), .out_pc_override(p_ovr), .out_pc_write(p_pcw)
    );

    switch_mcu_alu_seq #(.XLEN(32), .RADDR_W(5), .SHIFT_SERIAL(1)) u_ser (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_op(op),
        .in_rs1_data(rs1), .in_rs2_data(rs2), .in_imm(imm), .in_use_imm(use_imm),
        .in_pc(pc), .in_rd(rd), .out_busy(s_busy), .out_done(s_done),
        .out_illegal(s_ill), .out_wen(s_wen), .out_waddr(s_waddr),
        .out_wdata(s_wdata), .out_pc_override(s_ovr), .out_pc_write(s_pcw)
    );

    // Snapshot of one instance's outputs
    function automatic obs_t sample(input int i);
        obs_t s;
        if (i == 0) s = {p_busy, p_done, p_ill, p_wen, p_ovr, p_waddr, p_wdata, p_pcw};
        else        s = {s_busy, s_done, s_ill, s_wen, s_ovr, s_waddr, s_wdata, s_pcw};
        return s;
    endfunction

    // Reference behaviour computed directly from the instruction semantics
    function automatic exp_t refModel(input logic [4:0] o, input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] im, input logic ui, input logic [31:0] p,
                                      input logic [4:0] d);
        exp_t e;
        logic [31:0] b;
        int sa, sb;
        longint unsigned la, lb;
        bit writes, taken;
        b  = (ui && o <= 5'd9) ? im : r2;
        sa = $signed(r1);
        sb = $signed(b);
        la = r1;
        lb = b;
        e.wdata = 0; e.pcw = 0; e.ill = 0; e.is_shift = 0;
        e.shamt = int'(b % 32);
        writes = 1; taken = 0;
        case (o)
            5'd0:  e.wdata = 32'(la + lb);
            5'd1:  e.wdata = 32'(la - lb);
            5'd2:  begin e.is_shift = 1; e.wdata = 32'(la << e.shamt); end
            5'd3:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  e.wdata = (la < lb) ? 32'd1 : 32'd0;
            5'd5:  e.wdata = r1 ^ b;
            5'd6:  begin e.is_shift = 1; e.wdata = 32'(la >> e.shamt); end
            5'd7:  begin e.is_shift = 1; e.wdata = 32'(sa >>> e.shamt); end
            5'd8:  e.wdata = r1 | b;
            5'd9:  e.wdata = r1 & b;
            5'd10: e.wdata = im;
            5'd11: e.wdata = 32'(longint'(p) + longint'(im));
            5'd12: begin e.wdata = p + 32'd4; taken = 1; e.pcw = p + im; end
            5'd13: begin e.wdata = p + 32'd4; taken = 1; e.pcw = (r1 + im) & 32'hFFFF_FFFE; end
            5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
                writes = 0;
                case (o)
                    5'd14:   taken = (r1 == r2);
                    5'd15:   taken = (r1 != r2);
                    5'd16:   taken = ($signed(r1) < $signed(r2));
                    5'd17:   taken = ($signed(r1) >= $signed(r2));
                    5'd18:   taken = (r1 < r2);
                    default: taken = (r1 >= r2);
                endcase
                e.pcw = p + im;
            end
            default: begin writes = 0; e.ill = 1; end
        endcase
        e.wen = writes && (d != 5'd0);
        e.ovr = taken;
        return e;
    endfunction

    // One comparison: counts it, and reports it if it disagrees
    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request with start raised; called at a falling edge
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im, input logic ui, input logic [31:0] p,
                                 input logic [4:0] d);
        op = o; rs1 = r1; rs2 = r2; imm = im; use_imm = ui; pc = p; rd = d;
        start = 1'b1;
    endtask

    // Issue one op to both instances and check timing and results of each
    task automatic runOp(input string name, input logic [4:0] o, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic ui,
                         input logic [31:0] p, input logic [4:0] d);
        exp_t e;
        obs_t s;
        obs_t cap[2];
        int lat[2], doneAt[2], doneCnt[2], busyCnt[2];
        logic dirty[2];
        e = refModel(o, r1, r2, im, ui, p, d);
        lat[0] = 2;
        lat[1] = e.is_shift ? 2 + e.shamt : 2;
        for (int i = 0; i < 2; i++) begin
            cap[i] = '0; doneAt[i] = 0; doneCnt[i] = 0; busyCnt[i] = 0; dirty[i] = 1'b0;
        end
        applyStimulus(o, r1, r2, im, ui, p, d);
        @(posedge clk);
        for (int k = 1; k <= lat[1] + 1; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                s = sample(i);
                if (s.busy) busyCnt[i]++;
                if (s.done) begin
                    doneCnt[i]++;
                    if (doneAt[i] == 0) begin
                        doneAt[i] = k;
                        cap[i] = s;
                    end
                end else if (s.ill || s.wen || s.ovr || (|s.waddr) || (|s.wdata) || (|s.pcw)) begin
                    dirty[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s/%s:done_cycle", name, dn[i]), 80'(doneAt[i]), 80'(lat[i]));
            checkOutput($sformatf("%s/%s:done_count", name, dn[i]), 80'(doneCnt[i]), 80'd1);
            checkOutput($sformatf("%s/%s:busy_cycles", name, dn[i]), 80'(busyCnt[i]), 80'(lat[i]));
            checkOutput($sformatf("%s/%s:quiet_outside_done", name, dn[i]), 80'(dirty[i]), 80'd0);
            checkOutput($sformatf("%s/%s:wen", name, dn[i]), 80'(cap[i].wen), 80'(e.wen));
            checkOutput($sformatf("%s/%s:illegal", name, dn[i]), 80'(cap[i].ill), 80'(e.ill));
            checkOutput($sformatf("%s/%s:override", name, dn[i]), 80'(cap[i].ovr), 80'(e.ovr));
            if (e.wen) begin
                checkOutput($sformatf("%s/%s:wdata", name, dn[i]), 80'(cap[i].wdata), 80'(e.wdata));
                checkOutput($sformatf("%s/%s:waddr", name, dn[i]), 80'(cap[i].waddr), 80'(d));
            end
            if (e.ovr) begin
                checkOutput($sformatf("%s/%s:pc_write", name, dn[i]), 80'(cap[i].pcw), 80'(e.pcw));
            end
        end
    endtask

    // Start held high with changing operands must not disturb a serial shift
    task automatic holdStartTest();
        exp_t e;
        obs_t s;
        obs_t cap;
        int busyCnt, doneAt, doneCnt;
        busyCnt = 0; doneAt = 0; doneCnt = 0; cap = '0;
        e = refModel(5'd2, 32'd1, 32'd0, 32'd5, 1'b1, 32'd0, 5'd7);
        applyStimulus(5'd2, 32'd1, 32'd0, 32'd5, 1'b1, 32'd0, 5'd7);
        @(posedge clk);
        for (int k = 1; k <= 2 + e.shamt + 1; k++) begin
            @(negedge clk);
            s = sample(1);
            if (s.busy) busyCnt++;
            if (s.done) begin
                doneCnt++;
                if (doneAt == 0) begin doneAt = k; cap = s; end
            end
            if (k == 2) begin rs1 = 32'h0000_FFFF; imm = 32'd3; end
            if (k == 2 + e.shamt) start = 1'b0;
        end
        checkOutput("hold/ser:busy_cycles", 80'(busyCnt), 80'(2 + e.shamt));
        checkOutput("hold/ser:done_cycle", 80'(doneAt), 80'(2 + e.shamt));
        checkOutput("hold/ser:done_count", 80'(doneCnt), 80'd1);
        checkOutput("hold/ser:wdata", 80'(cap.wdata), 80'(e.wdata));
        checkOutput("hold/ser:waddr", 80'(cap.waddr), 80'd7);
    endtask

    // Reset asserted in the middle of a serial shift must abandon it silently
    task automatic resetMidShiftTest();
        obs_t s;
        int busyCnt, doneCnt;
        busyCnt = 0; doneCnt = 0;
        applyStimulus(5'd6, 32'h0000_00F0, 32'd0, 32'd10, 1'b1, 32'd0, 5'd4);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            s = sample(1);
            if (s.busy) busyCnt++;
        end
        checkOutput("rstmid/ser:busy_before_reset", 80'(busyCnt), 80'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid/par:outputs_in_reset", 80'(sample(0)), 80'd0);
        checkOutput("rstmid/ser:outputs_in_reset", 80'(sample(1)), 80'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        busyCnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                s = sample(i);
                if (s.busy) busyCnt++;
                if (s.done) doneCnt++;
            end
        end
        checkOutput("rstmid:busy_after_reset", 80'(busyCnt), 80'd0);
        checkOutput("rstmid:done_after_reset", 80'(doneCnt), 80'd0);
        checkOutput("rstmid/ser:outputs_idle", 80'(sample(1)), 80'd0);
    endtask

    // Directed steps, then randomized ops, then the summary line
    initial begin
        logic [4:0]  ro;
        logic [31:0] r1, r2;
        start = 1'b0; op = '0; rs1 = '0; rs2 = '0; imm = '0; use_imm = 1'b0; pc = '0; rd = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset/par:outputs", 80'(sample(0)), 80'd0);
        checkOutput("reset/ser:outputs", 80'(sample(1)), 80'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp("add_wrap",   5'd0,  32'hFFFF_FFFF, 32'd1,  32'd0,         1'b0, 32'd0,         5'd3);
        runOp("sra_imm4",   5'd7,  32'h8000_0000, 32'd0,  32'd4,         1'b1, 32'd0,         5'd5);
        runOp("blt_taken",  5'd16, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFF8, 1'b0, 32'h100,       5'd2);
        runOp("bltu_not",   5'd18, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFF8, 1'b0, 32'h100,       5'd2);
        runOp("jalr",       5'd13, 32'h203,       32'd0,  32'd4,         1'b0, 32'h40,        5'd1);
        runOp("illegal25",  5'd25, 32'h1234,      32'h55, 32'd8,         1'b0, 32'h80,        5'd4);
        runOp("lui",        5'd10, 32'd0,         32'd0,  32'h1234_5000, 1'b0, 32'd0,         5'd9);
        runOp("auipc_wrap", 5'd11, 32'd0,         32'd0,  32'h0000_2000, 1'b0, 32'hFFFF_F000, 5'd6);
        runOp("jal_rd0",    5'd12, 32'd0,         32'd0,  32'h10,        1'b0, 32'h80,        5'd0);
        runOp("sll_zero",   5'd2,  32'hA5A5_0001, 32'h20, 32'd0,         1'b0, 32'd0,         5'd8);
        runOp("sub_wrap",   5'd1,  32'd0,         32'd1,  32'd0,         1'b0, 32'd0,         5'd31);
        runOp("bgeu_eq",    5'd19, 32'd5,         32'd5,  32'h20,        1'b0, 32'h200,       5'd3);
        runOp("srl_31",     5'd6,  32'h8000_0000, 32'd31, 32'd0,         1'b0, 32'd0,         5'd10);

        holdStartTest();
        resetMidShiftTest();

        for (int n = 0; n < 80; n++) begin
            ro = 5'($urandom_range(0, 25));
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            runOp($sformatf("rand%0d_op%0d", n, ro), ro, r1, r2, $urandom,
                  1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a run that never ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
